button_event_encoder: RTL and testbench

Sequential front end that produces the processor's software-input code (swCode). It synchronises and debounces the raw push-buttons, detects press edges, and buffers press events in a small FIFO. It presents each event to the core as a non-zero code for exactly one clock. The processor stalls on a non-zero code and writes it to r25, so each press yields exactly one r25 write.

---
 rtl/button_pkg.sv | 15 +
 rtl/button_debouncer.sv | 43 ++++
 rtl/button_event_encoder.sv | 110 +++++++++++
 tb/tb_button_event_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the push-button event path feeding the core's swCode input.
package button_pkg;

    localparam int BTN_CODE_NONE    = 0;
    localparam int BTN_CODE_BASE    = 1;
    localparam int DROP_COUNT_WIDTH = 8;

    // Writeback steers a non-zero swCode into this register.
    localparam logic [4:0] REG_DEST_R25 = 5'd25;

    function automatic int btnCode(input int index);
        return BTN_CODE_BASE + index;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, stability counter and accepted level.
// rise_pulse is a one-cycle strobe aligned with stable going 0->1.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic buttonRaw,
    output logic stable,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             syncOut;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            syncMeta   <= 1'b0;
            syncOut    <= 1'b0;
            stable     <= 1'b0;
            rise_pulse <= 1'b0;
            count      <= '0;
        end else begin
            syncMeta   <= buttonRaw;
            syncOut    <= syncMeta;
            rise_pulse <= 1'b0;
            if (syncOut == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable     <= syncOut;
                rise_pulse <= syncOut;
                count      <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_encoder.sv
// Debounced button presses queued in a small FIFO and presented to the core
// as one-cycle non-zero codes, always separated by at least one zero cycle.
module button_event_encoder
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CODE_WIDTH      = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_BUTTONS-1:0]        buttons,
    output logic [CODE_WIDTH-1:0]         sw_code,
    output logic                          sw_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] stableLevels;
    logic [NUM_BUTTONS-1:0] risePulses;
    logic [NUM_BUTTONS-1:0] pressEdge;
    logic [NUM_BUTTONS-1:0] pending;
    logic [NUM_BUTTONS-1:0] pendingClear;
    logic                   pendingAny;
    logic [CODE_WIDTH-1:0]  pendingCode;

    logic [AW:0]            wrPtr;
    logic [AW:0]            rdPtr;
    logic [CODE_WIDTH-1:0]  fifoMem [FIFO_DEPTH];
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic                   gap;
    logic                   push;
    logic                   pop;
    logic                   drop;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : gen_debounce
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock     (clock),
            .reset     (reset),
            .buttonRaw (buttons[g]),
            .stable    (stableLevels[g]),
            .rise_pulse(risePulses[g])
        );
    end

    assign pressEdge = risePulses & stableLevels;

    // Lowest index wins; the loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        pendingClear = '0;
        pendingAny   = 1'b0;
        pendingCode  = CODE_WIDTH'(BTN_CODE_NONE);
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pendingClear    = '0;
                pendingClear[i] = 1'b1;
                pendingAny      = 1'b1;
                pendingCode     = CODE_WIDTH'(btnCode(i));
            end
        end
    end

    assign fifoEmpty  = (wrPtr == rdPtr);
    assign fifoFull   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign fifo_level = wrPtr - rdPtr;

    // A pop frees the head slot on the same edge, so a full FIFO still accepts a push.
    assign pop  = !fifoEmpty && !gap;
    assign push = pendingAny && (!fifoFull || pop);
    assign drop = pendingAny && fifoFull && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending    <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            gap        <= 1'b0;
            sw_code    <= CODE_WIDTH'(BTN_CODE_NONE);
            sw_valid   <= 1'b0;
            drop_count <= '0;
        end else begin
            pending  <= (pending & ~pendingClear) | pressEdge;
            gap      <= pop;
            sw_valid <= pop;
            sw_code  <= pop ? fifoMem[rdPtr[AW-1:0]] : CODE_WIDTH'(BTN_CODE_NONE);
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr[AW-1:0]] <= pendingCode;
        end
    end

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench: dutA uses the nominal debounce length, dutB a 1-cycle debounce
// so the FIFO can be overrun by toggling two buttons at full rate.
module tb_button_event_encoder;

    logic        clk = 1'b0;
    logic        rstA, rstB;
    logic [2:0]  btnA, btnB;
    logic [31:0] codeA, codeB;
    logic        validA, validB;
    logic [2:0]  levelA, levelB;
    logic [7:0]  dropA, dropB;

    always #5 clk = ~clk;

    button_event_encoder #(
        .NUM_BUTTONS(3), .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .CODE_WIDTH(32)
    ) dutA (
        .clock(clk), .reset(rstA), .buttons(btnA), .sw_code(codeA),
        .sw_valid(validA), .fifo_level(levelA), .drop_count(dropA)
    );

    button_event_encoder #(
        .NUM_BUTTONS(3), .DEBOUNCE_CYCLES(1), .FIFO_DEPTH(4), .CODE_WIDTH(32)
    ) dutB (
        .clock(clk), .reset(rstB), .buttons(btnB), .sw_code(codeB),
        .sw_valid(validB), .fifo_level(levelB), .drop_count(dropB)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitors, sampled on the falling edge.
    logic       monEn      = 1'b0;
    logic       prevValidA = 1'b0;
    logic       prevValidB = 1'b0;
    logic [7:0] prevDropB  = 8'd0;
    int         evCountA   = 0;
    int         protoErrA  = 0;
    int         protoErrB  = 0;
    int         peakLevelA = 0;
    int         peakLevelB = 0;
    int         dropDecB   = 0;
    int         codesB[$];

    always @(negedge clk) begin
        if (monEn) begin
            if (validA !== (codeA != 32'd0)) protoErrA++;
            if (validA === 1'b1) begin
                evCountA++;
                if (prevValidA) protoErrA++;
            end
            prevValidA = validA;
            if (int'(levelA) > peakLevelA) peakLevelA = int'(levelA);

            if (validB !== (codeB != 32'd0)) protoErrB++;
            if (validB === 1'b1) begin
                codesB.push_back(int'(codeB));
                if (prevValidB) protoErrB++;
            end
            prevValidB = validB;
            if (int'(levelB) > peakLevelB) peakLevelB = int'(levelB);
            if (rstB) begin
                prevDropB = 8'd0;
            end else begin
                if (dropB < prevDropB) dropDecB++;
                prevDropB = dropB;
            end
        end
    end

    logic [31:0] obs [0:26];
    logic        obsValid [0:26];
    int          evBase;
    int          expSeq [0:6] = '{0, 1, 0, 2, 0, 3, 0};
    int          expOvf [0:9] = '{1, 2, 1, 2, 1, 2, 1, 2, 2, 2};

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        btnA = 3'b000;
        btnB = 3'b000;
        repeat (3) tick();

        checkVal("rst_codeA",  codeA, 0);
        checkVal("rst_validA", 32'(validA), 0);
        checkVal("rst_levelA", 32'(levelA), 0);
        checkVal("rst_dropA",  32'(dropA), 0);
        checkVal("rst_codeB",  codeB, 0);
        checkVal("rst_levelB", 32'(levelB), 0);
        checkVal("rst_dropB",  32'(dropB), 0);

        rstA  = 1'b0;
        rstB  = 1'b0;
        monEn = 1'b1;
        repeat (2) tick();

        // Single press on button 1: code 2 at exactly 20 clocks.
        btnA = 3'b010;
        for (int k = 0; k <= 22; k++) begin
            tick();
            obs[k]      = codeA;
            obsValid[k] = validA;
        end
        checkVal("single_k19",   obs[19], 0);
        checkVal("single_k20",   obs[20], 2);
        checkVal("single_valid", 32'(obsValid[20]), 1);
        checkVal("single_k21",   obs[21], 0);

        evBase = evCountA;
        btnA   = 3'b000;
        repeat (40) tick();
        checkVal("release_no_event", 32'(evCountA - evBase), 0);

        // Glitch of 10 cycles on button 0.
        evBase     = evCountA;
        peakLevelA = 0;
        btnA       = 3'b001;
        repeat (10) tick();
        btnA = 3'b000;
        repeat (30) tick();
        checkVal("glitch_events", 32'(evCountA - evBase), 0);
        checkVal("glitch_level",  32'(peakLevelA), 0);

        // Simultaneous press: 1, 2, 3 with single zero gaps.
        evBase = evCountA;
        btnA   = 3'b111;
        for (int k = 0; k <= 26; k++) begin
            tick();
            obs[k] = codeA;
        end
        for (int j = 0; j < 7; j++) begin
            checkVal($sformatf("simul_k%0d", 19 + j), obs[19 + j], 32'(expSeq[j]));
        end
        checkVal("simul_count", 32'(evCountA - evBase), 3);
        btnA = 3'b000;
        repeat (30) tick();

        // Reset with events in flight, buttons held through it.
        btnA = 3'b111;
        for (int k = 0; k <= 19; k++) tick();
        checkVal("rstmid_pre_level", 32'(levelA), 1);
        rstA = 1'b1;
        tick();
        checkVal("rstmid_code",  codeA, 0);
        checkVal("rstmid_valid", 32'(validA), 0);
        checkVal("rstmid_level", 32'(levelA), 0);
        rstA   = 1'b0;
        evBase = evCountA;
        for (int k = 0; k <= 26; k++) begin
            tick();
            obs[k] = codeA;
        end
        for (int j = 0; j < 7; j++) begin
            checkVal($sformatf("rstmid_k%0d", 19 + j), obs[19 + j], 32'(expSeq[j]));
        end
        repeat (20) tick();
        checkVal("rstmid_count", 32'(evCountA - evBase), 3);
        btnA = 3'b000;
        repeat (30) tick();

        // Overflow: buttons 1:0 toggled at full rate, 6 presses each.
        codesB.delete();
        peakLevelB = 0;
        for (int p = 0; p < 6; p++) begin
            btnB = 3'b011;
            tick();
            btnB = 3'b000;
            tick();
        end
        repeat (30) tick();
        checkVal("ovf_emitted", 32'(codesB.size()), 10);
        for (int i = 0; i < 10; i++) begin
            checkVal($sformatf("ovf_code%0d", i),
                     (i < codesB.size()) ? 32'(codesB[i]) : 32'd0, 32'(expOvf[i]));
        end
        checkVal("ovf_peak_level", 32'(peakLevelB), 4);
        checkVal("ovf_drops",      32'(dropB), 2);
        checkVal("ovf_drained",    32'(levelB), 0);

        // Drop counter saturation.
        rstB = 1'b1;
        tick();
        rstB = 1'b0;
        for (int p = 0; p < 300; p++) begin
            btnB = 3'b011;
            tick();
            btnB = 3'b000;
            tick();
        end
        repeat (30) tick();
        checkVal("sat_drop_count", 32'(dropB), 255);
        checkVal("sat_no_wrap",    32'(dropDecB), 0);
        checkVal("sat_drained",    32'(levelB), 0);

        checkVal("protocol_A", 32'(protoErrA), 0);
        checkVal("protocol_B", 32'(protoErrB), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
